// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: datapath widths, MEM/WB control bundle
// and ALU control encodings.
package rv32_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   // Control bits travelling from EX to MEM/WB
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // ALU operation encodings
   typedef enum logic [2:0] {
      ALU_ADD = 3'b001,
      ALU_SUB = 3'b010,
      ALU_XOR = 3'b011,
      ALU_OR  = 3'b100,
      ALU_AND = 3'b101
   } alu_op_e;

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised pipeline register: async active-low reset,
// synchronous clear (bubble) that beats the load enable.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   // Clear wins over load; with neither, the value is held
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         q_o <= '0;
      else if (clear_i)
         q_o <= '0;
      else if (load_i)
         q_o <= d_i;
   end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the RV32I core. Holds on stall or data
// memory busy, zeroes on flush, and gates write enables with valid so
// bubbles never write state. Also counts held cycles (saturating).
module ex_mem #(
   parameter int DATA_W = rv32_pkg::DATA_W,
   parameter int REG_AW = rv32_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              mem_busy_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] rs2_data_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic              reg_write_i,
   input  logic              mem_to_reg_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [DATA_W-1:0] rs2_data_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              reg_write_o,
   output logic              mem_to_reg_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic              hold_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   import rv32_pkg::*;

   localparam int DW = 2 * DATA_W + REG_AW;
   localparam int CW = 1 + CTRL_W;

   logic          hold;
   ctrl_t         ctrl_in;
   ctrl_t         ctrl_q;
   logic          valid_q;
   logic [DW-1:0] data_q;
   logic [CW-1:0] ctrl_bus_q;
   logic [CNT_W-1:0] stall_cnt_reg;

   // Hold goes upstream without delay so earlier stages freeze this cycle
   assign hold   = stall_i | mem_busy_i;
   assign hold_o = hold;

   assign ctrl_in = '{reg_write:  reg_write_i,
                      mem_to_reg: mem_to_reg_i,
                      mem_read:   mem_read_i,
                      mem_write:  mem_write_i};

   pipe_reg #(.W(DW)) u_data (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (~hold),
      .clear_i (flush_i),
      .d_i     ({alu_result_i, rs2_data_i, rd_addr_i}),
      .q_o     (data_q)
   );

   pipe_reg #(.W(CW)) u_ctrl (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (~hold),
      .clear_i (flush_i),
      .d_i     ({valid_i, ctrl_in}),
      .q_o     (ctrl_bus_q)
   );

   assign valid_q = ctrl_bus_q[CW-1];
   assign ctrl_q  = ctrl_bus_q[CTRL_W-1:0];

   assign valid_o      = valid_q;
   assign alu_result_o = data_q[DW-1 -: DATA_W];
   assign rs2_data_o   = data_q[REG_AW +: DATA_W];
   assign rd_addr_o    = data_q[REG_AW-1:0];

   // Write-side enables are gated by valid so stale bits in a bubble are harmless
   assign reg_write_o  = valid_q & ctrl_q.reg_write;
   assign mem_to_reg_o = ctrl_q.mem_to_reg;
   assign mem_read_o   = valid_q & ctrl_q.mem_read;
   assign mem_write_o  = valid_q & ctrl_q.mem_write;

   // Count cycles in which the register really held (a flush is not a hold)
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         stall_cnt_reg <= '0;
      else if (hold && !flush_i && (stall_cnt_reg != {CNT_W{1'b1}}))
         stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline register between the execute and memory stages of the RV32I core.
- Captures the ALU result, the store data (forwarded rs2), the destination register index and the MEM/WB control bits at each clock.
- Supports three upstream controls: stall/hold (hazard unit or data-memory busy), flush/bubble (branch redirect), and a valid bit so downstream stages ignore bubbles.
- Also keeps a saturating count of stalled cycles for debug.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data).
- REG_AW, 5, register index width.
- CNT_W, 16, stall-cycle counter width.

Ports:
- clk_i  in  1  core clock, rising-edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-unit hold request.
- mem_busy_i  in  1  data memory not ready; holds the register like stall_i.
- flush_i  in  1  insert a bubble (branch/jump redirect).
- valid_i  in  1  EX stage holds a real instruction.
- alu_result_i  in  DATA_W  from ALU result.
- rs2_data_i  in  DATA_W  forwarded rs2 value (store data).
- rd_addr_i  in  REG_AW  destination register.
- reg_write_i  in  1  WB control.
- mem_to_reg_i  in  1  WB control.
- mem_read_i  in  1  MEM control.
- mem_write_i  in  1  MEM control.
- valid_o  out  1  MEM stage holds a real instruction.
- alu_result_o  out  DATA_W  registered ALU result / memory address.
- rs2_data_o  out  DATA_W  registered store data.
- rd_addr_o  out  REG_AW  registered destination.
- reg_write_o  out  1  gated: valid_o & captured reg_write.
- mem_to_reg_o  out  1  registered.
- mem_read_o  out  1  gated by valid_o.
- mem_write_o  out  1  gated by valid_o.
- hold_o  out  1  combinational stall_i | mem_busy_i, sent to the upstream stages.
- stall_cnt_o  out  CNT_W  saturating count of held cycles.

Behaviour:
- Reset (rst_n_i low, asynchronous): all registered outputs are 0 (valid_o=0, data=0, rd=0, control=0, stall_cnt_o=0). The reset takes effect immediately, even in the middle of a stall. The first capture happens on the first rising edge after release.
- Let hold = stall_i | mem_busy_i. The per-edge priority is reset > flush > hold > load.
- flush_i=1: valid_o<=0 and every control bit <=0. The data fields (alu_result_o, rs2_data_o, rd_addr_o) <=0. Flush wins over hold, even when both are asserted in the same cycle.
- hold=1 with flush_i=0: every register keeps its value. stall_cnt_o increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- Otherwise (load): capture all *_i fields, and valid_o<=valid_i.
- valid_i=0 on a load: the data fields are still captured, but valid_o=0. Every write-side control output is forced to 0 by the valid gating.
- Latency: exactly 1 cycle from input to output when there is no hold.
- The write-enable gating (reg_write_o, mem_read_o, mem_write_o = captured bit & valid_o) is combinational on the register outputs. A bubble therefore never writes the register file or memory, whatever its stale control bits are.
- hold_o has no registered delay. Upstream stages must hold in the same cycle.
- No arithmetic on the datapath. The only arithmetic is the counter: unsigned, CNT_W bits, +1 with saturation.
- The register never drops a held instruction. It updates only on a load or a flush.

Decomposition:
- Shared package rv32_pkg holds:
  - the DATA_W and REG_AW constants;
  - a MEM/WB control bundle type with fields reg_write, mem_to_reg, mem_read, mem_write;
  - the ALU control encodings (ADD=001, SUB=010, XOR=011, OR=100, AND=101).
- One natural sub-module, pipe_reg: a width-parameterised register with async active-low reset, enable (load) and synchronous clear (flush). It is instantiated for the data bundle and for the control/valid bundle. The saturating counter stays in ex_mem.

Test Plan:
- Reset: assert rst_n_i=0 mid-cycle with a valid instruction held -> all outputs 0 immediately, with no clock edge needed. After release, first edge loads alu_result_i=0x0000_0010 -> alu_result_o=0x10, valid_o=1.
- Pass-through: 3 back-to-back loads with alu_result_i = 0x1, 0xFFFF_FFFF, 0x8000_0000 and rd = 1, 2, 3, reg_write=1 -> each appears exactly 1 cycle later, reg_write_o=1.
- Stall: load a store (mem_write_i=1, rs2=0xDEAD_BEEF), then mem_busy_i=1 for 4 cycles while the inputs change -> outputs are frozen at 0xDEAD_BEEF with mem_write_o=1, hold_o=1, and stall_cnt_o goes 0→4.
- Flush priority: stall_i=1 and flush_i=1 in the same cycle with a valid load held -> next edge valid_o=0, reg_write_o=0, mem_write_o=0, data fields=0.
- Bubble gating: valid_i=0 with reg_write_i=1, mem_write_i=1 -> valid_o=0, reg_write_o=0, mem_write_o=0.
- Counter saturation (CNT_W=4): hold for 20 cycles -> stall_cnt_o stops at 15 and never wraps to 0.
